// File: rtl/line_memory_responder.sv
// Line-granular memory responder for the data cache's fill/write-back port.
// Accepts one line request at a time, answers LATENCY cycles later with a
// single-cycle ack, and flags any initiator that disturbs an in-flight request.
`timescale 1ns/1ps
module line_memory_responder #(
    parameter int LINE_BITS   = 256,
    parameter int ADDR_BITS   = 32,
    parameter int DEPTH_LINES = 512,
    parameter int LATENCY     = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o,
    output logic                 busy_o,
    output logic                 proto_err_o
);

    localparam int IDX_BITS = $clog2(DEPTH_LINES);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t               state;
    state_t               next_state;
    logic [7:0]           counter;
    logic                 lat_write;
    logic [IDX_BITS-1:0]  lat_index;
    logic [LINE_BITS-1:0] lat_data;
    logic [IDX_BITS-1:0]  index;
    logic [IDX_BITS-1:0]  rd_index;
    logic                 rd_write;
    logic                 field_changed;
    logic                 unused_addr_bits;

    logic [LINE_BITS-1:0] mem [DEPTH_LINES];

    // Line offset and upper bits take no part in addressing; upper bits wrap.
    assign index            = addr_i[IDX_BITS+4:5];
    assign unused_addr_bits = ^{addr_i[ADDR_BITS-1:IDX_BITS+5], addr_i[4:0]};

    // When ACK is entered straight from IDLE the request is not latched yet.
    assign rd_index = (state == IDLE) ? index   : lat_index;
    assign rd_write = (state == IDLE) ? write_i : lat_write;

    assign ack_o  = (state == ACK);
    assign busy_o = (state != IDLE);

    assign field_changed = !enable_i
                         || (write_i != lat_write)
                         || (index != lat_index)
                         || (lat_write && (data_i != lat_data));

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // see the same pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode.
    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (enable_i) next_state = (LATENCY == 1) ? ACK : WAIT;
            WAIT: if (counter == 8'd1) next_state = ACK;
            ACK:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request at acceptance and run the latency countdown.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            counter   <= '0;
            lat_write <= 1'b0;
            lat_index <= '0;
            lat_data  <= '0;
        end else if (state == IDLE && enable_i) begin
            counter   <= 8'(LATENCY - 1);
            lat_write <= write_i;
            lat_index <= index;
            lat_data  <= data_i;
        end else if (state == WAIT) begin
            counter   <= counter - 8'd1;
        end
    end

    // Read data register: loaded on entry to ACK for reads, held otherwise.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            data_o <= '0;
        else if (next_state == ACK && state != ACK && !rd_write)
            data_o <= mem[rd_index];
    end

    // Commit a write at the edge that ends ACK.
    // NOTE: the array is deliberately outside reset so it maps onto plain RAM
    // and keeps its contents across a reset.
    always_ff @(posedge clk_i) begin
        if (state == ACK && lat_write)
            mem[lat_index] <= lat_data;
    end

    // Sticky protocol-violation flag for disturbed in-flight requests.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            proto_err_o <= 1'b0;
        else if (state != IDLE && field_changed)
            proto_err_o <= 1'b1;
    end

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder with a read-data scoreboard and
// a line-level reference model of the memory contents.
`timescale 1ns/1ps
module tb_line_memory_responder;

    localparam int LAT   = 10;
    localparam int DEPTH = 512;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;
    logic         proto_err_o;

    int passed = 0;
    int total  = 0;

    logic [255:0] model [DEPTH];
    logic [255:0] exp_q [$];
    logic [255:0] last_data;
    bit           exp_proto;

    line_memory_responder #(
        .LINE_BITS(256), .ADDR_BITS(32), .DEPTH_LINES(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
        .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int lidx(input logic [31:0] addr);
        return int'((addr % (DEPTH * 32)) / 32);
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_ack"},   256'(ack_o),       256'(0));
        check({tag, "_busy"},  256'(busy_o),      256'(0));
        check({tag, "_perr"},  256'(proto_err_o), 256'(0));
        check({tag, "_data"},  data_o,            256'(0));
    endtask

    // Issue one request from an IDLE cycle (called #1 after a rising edge).
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                          input bit hold, input bit corrupt);
        int  n;
        bit  got;
        logic [255:0] exp;
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = d;
        if (!wr) exp_q.push_back(model[lidx(addr)]);
        @(negedge clk_i);
        check("idle_busy", 256'(busy_o), 256'(0));
        check("idle_ack",  256'(ack_o),  256'(0));
        @(posedge clk_i);
        got = 1'b0;
        n   = 0;
        while (!got && n < LAT + 20) begin
            n++;
            @(negedge clk_i);
            if (ack_o) got = 1'b1;
            else begin
                check("wait_busy", 256'(busy_o), 256'(1));
                if (corrupt && n == 3) addr_i = addr ^ 32'h0000_00C0;
                @(posedge clk_i);
            end
        end
        check("ack_seen",    256'(got), 256'(1));
        check("ack_latency", 256'(n),   256'(LAT));
        check("ack_busy",    256'(busy_o), 256'(1));
        if (!wr) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("read_data", data_o, exp);
            last_data = exp;
        end else begin
            check("write_keeps_data", data_o, last_data);
            model[lidx(addr)] = d;
        end
        check("proto_err", 256'(proto_err_o), 256'(exp_proto));
        @(posedge clk_i);
        #1;
        if (!hold) enable_i = 1'b0;
    endtask

    initial begin
        logic [255:0] pat_a5, pat_1234, pat_old, pat_new, pat_wrap, pat_hold;
        pat_a5   = {32{8'hA5}};
        pat_1234 = {16{16'h1234}};
        pat_old  = {8{32'hDEAD_BEEF}};
        pat_new  = {8{32'h0BAD_F00D}};
        pat_wrap = {4{64'h0123_4567_89AB_CDEF}};
        pat_hold = {8{32'h5A5A_0F0F}};
        exp_proto = 1'b0;
        last_data = '0;

        rst_i = 1'b0; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
        #12;
        check_outputs_reset("reset");
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Preload lines through the interface.
        do_req(1'b1, 32'h0000_0040, pat_a5,  1'b0, 1'b0);
        do_req(1'b1, 32'h0000_0200, pat_old, 1'b0, 1'b0);

        // Basic read with exact latency.
        do_req(1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);

        // Write then read back; write ack keeps data_o.
        do_req(1'b1, 32'h0000_0100, pat_1234, 1'b0, 1'b0);
        do_req(1'b0, 32'h0000_0100, '0,       1'b0, 1'b0);

        // Address wrap: 0x4020 and 0x20 are both line 1.
        do_req(1'b1, 32'h0000_4020, pat_wrap, 1'b0, 1'b0);
        do_req(1'b0, 32'h0000_0020, '0,       1'b0, 1'b0);

        // Back-to-back: enable held through ack, read-after-write same line.
        do_req(1'b1, 32'h0000_0100, pat_hold, 1'b1, 1'b0);
        do_req(1'b0, 32'h0000_0100, '0,       1'b0, 1'b0);

        // Address disturbed during WAIT: flag set, original line returned.
        exp_proto = 1'b1;
        do_req(1'b0, 32'h0000_0040, '0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("proto_sticky", 256'(proto_err_o), 256'(1));
        @(posedge clk_i); #1;

        // Reset during WAIT of a write aborts it.
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0200; data_i = pat_new;
        @(posedge clk_i);
        repeat (3) begin
            @(negedge clk_i);
            check("abort_no_ack", 256'(ack_o),  256'(0));
            check("abort_busy",   256'(busy_o), 256'(1));
        end
        #2 rst_i = 1'b0;
        #1;
        check_outputs_reset("mid_reset");
        enable_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs_reset("held_reset");
        rst_i = 1'b1;
        exp_proto = 1'b0;
        last_data = '0;
        repeat (LAT + 2) begin
            @(negedge clk_i);
            check("post_abort_no_ack", 256'(ack_o), 256'(0));
        end
        @(posedge clk_i); #1;
        do_req(1'b0, 32'h0000_0200, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
